// File: rtl/rv_halt_dump.sv
// rtl/rv_halt_dump.sv - halts the core on ECALL/EBREAK, streams the register file, reports pass/fail
module rv_halt_dump #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned STATUS_REG = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inst_valid,
  input  logic [31:0]     inst,
  output logic            halted,
  output logic [4:0]      reg_raddr,
  input  logic [XLEN-1:0] reg_rdata,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [4:0]      dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            done,
  output logic            pass,
  output logic [XLEN-2:0] fail_test
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

  state_t          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [XLEN-1:0] status_q, status_d;
  logic            halted_q, halted_d;
  logic            dump_valid_q, dump_valid_d;
  logic [4:0]      dump_idx_q, dump_idx_d;
  logic [XLEN-1:0] dump_data_q, dump_data_d;
  logic            trigger;
  logic            is_status;

  // Only plain ECALL/EBREAK; CSR ops and other SYSTEM encodings pass through.
  assign trigger = inst_valid && (inst[6:0] == 7'b1110011) && (inst[14:12] == 3'b000) &&
                   ((inst[31:20] == 12'h000) || (inst[31:20] == 12'h001));

  // Never true when STATUS_REG lies outside the dumped range, leaving status at 0.
  assign is_status = ({27'd0, idx_q} == 32'(STATUS_REG));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    status_d     = status_q;
    halted_d     = halted_q;
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          halted_d = 1'b1;
          idx_d    = 5'd0;
          state_d  = READ;
        end
      end
      READ: begin
        dump_data_d  = reg_rdata;
        dump_idx_d   = idx_q;
        dump_valid_d = 1'b1;
        if (is_status) status_d = reg_rdata;
        state_d = SEND;
      end
      SEND: begin
        if (dump_valid_q && dump_ready) begin
          dump_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = READ;
          end
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 5'd0;
      status_q     <= '0;
      halted_q     <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= 5'd0;
      dump_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      status_q     <= status_d;
      halted_q     <= halted_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
    end
  end

  // idx only moves on the handshake that re-enters READ, so it doubles as the read address.
  assign reg_raddr  = idx_q;
  assign halted     = halted_q;
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;
  assign done       = (state_q == DONE);
  assign pass       = done && (status_q == XLEN'(1));
  assign fail_test  = done ? status_q[XLEN-1:1] : '0;

endmodule

// File: tb/tb_rv_halt_dump.sv
// tb/tb_rv_halt_dump.sv - directed scoreboard bench for rv_halt_dump
module tb_rv_halt_dump;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            inst_valid = 1'b0;
  logic [31:0]     inst = 32'h0000_0013;
  logic            halted;
  logic [4:0]      reg_raddr;
  logic [XLEN-1:0] reg_rdata;
  logic            dump_valid;
  logic            dump_ready = 1'b0;
  logic [4:0]      dump_idx;
  logic [XLEN-1:0] dump_data;
  logic            done;
  logic            pass;
  logic [XLEN-2:0] fail_test;

  logic [XLEN-1:0] regs [32];

  typedef struct packed {
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
  } beat_t;
  beat_t sbq[$];

  int n_cmp = 0;
  int n_fail = 0;

  rv_halt_dump dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst       (inst),
    .halted     (halted),
    .reg_raddr  (reg_raddr),
    .reg_rdata  (reg_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .done       (done),
    .pass       (pass),
    .fail_test  (fail_test)
  );

  assign reg_rdata = regs[reg_raddr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    chk({tag, "_valid"}, 64'(dump_valid), 64'd0);
    chk({tag, "_idx"}, 64'(dump_idx), 64'd0);
    chk({tag, "_data"}, 64'(dump_data), 64'd0);
    chk({tag, "_raddr"}, 64'(reg_raddr), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_fail"}, 64'(fail_test), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    @(negedge clk);
  endtask

  task automatic fire(input logic [31:0] w);
    inst_valid = 1'b1;
    inst = w;
    for (int i = 0; i < 32; i++) sbq.push_back('{idx: 5'(i), data: regs[i]});
    @(negedge clk);
    inst_valid = 1'b0;
    inst = 32'h0000_0013;
    chk("halted_after_trigger", 64'(halted), 64'd1);
  endtask

  task automatic run_dump(input int stall_idx, input int abort_idx, input bit retrig, output int done_cyc);
    int    stall;
    beat_t held;
    beat_t exp_b;
    stall = 0;
    done_cyc = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (retrig) begin
        inst_valid = (cyc == 10);
        inst = (cyc == 10) ? 32'h0000_0073 : 32'h0000_0013;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      dump_ready = 1'b1;
      if (stall > 0 && stall < 7) begin
        dump_ready = 1'b0;
        chk("stall_valid", 64'(dump_valid), 64'd1);
        chk("stall_idx", 64'(dump_idx), 64'(held.idx));
        chk("stall_data", 64'(dump_data), 64'(held.data));
        stall++;
      end else if (dump_valid) begin
        if (int'(dump_idx) == abort_idx) begin
          rst_n = 1'b0;
          #1;
          chk_all_zero("async_abort");
          sbq.delete();
          inst_valid = 1'b0;
          return;
        end
        if (int'(dump_idx) == stall_idx && stall == 0) begin
          dump_ready = 1'b0;
          held = '{idx: dump_idx, data: dump_data};
          stall = 1;
        end else if (sbq.size() == 0) begin
          chk("unexpected_beat_idx", 64'(dump_idx), 64'hFFFF);
        end else begin
          exp_b = sbq.pop_front();
          chk("beat_idx", 64'(dump_idx), 64'(exp_b.idx));
          chk("beat_data", 64'(dump_data), 64'(exp_b.data));
        end
      end
      @(negedge clk);
    end
    inst_valid = 1'b0;
    inst = 32'h0000_0013;
    if (done_cyc < 0) chk("dump_timeout_done", 64'(done), 64'd1);
  endtask

  task automatic check_done(input int done_cyc, input int exp_cyc, input logic exp_pass, input logic [XLEN-2:0] exp_fail);
    chk("done_cycle", 64'(done_cyc), 64'(exp_cyc));
    chk("done_pass", 64'(pass), 64'(exp_pass));
    chk("done_fail_test", 64'(fail_test), 64'(exp_fail));
    chk("beats_outstanding", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("post_done_valid", 64'(dump_valid), 64'd0);
    chk("post_done_sticky", 64'(done), 64'd1);
    chk("post_done_halted", 64'(halted), 64'd1);
  endtask

  initial begin
    int dc;
    logic [31:0] idle_words [5];

    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 16 + 5);
    regs[3] = 32'd1;

    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // NOP, MRET, imm12=2, funct3=1 must not trigger; nor a non-valid ECALL.
    idle_words[0] = 32'h0000_0013;
    idle_words[1] = 32'h3020_0073;
    idle_words[2] = 32'h0020_0073;
    idle_words[3] = 32'h0000_1073;
    idle_words[4] = 32'h0000_0073;
    for (int k = 0; k < 5; k++) begin
      inst_valid = (k != 4);
      inst = idle_words[k];
      @(negedge clk);
      inst_valid = 1'b0;
      inst = 32'h0000_0013;
      @(negedge clk);
      chk("idle_no_halt", 64'(halted), 64'd0);
    end

    fire(32'h0000_0073);
    run_dump(-1, -1, 1'b1, dc);
    check_done(dc, 64, 1'b1, '0);

    do_reset();
    regs[3] = 32'h0000_000B;
    regs[10] = 32'hDEAD_BEEF;
    fire(32'h0010_0073);
    run_dump(10, -1, 1'b0, dc);
    check_done(dc, 71, 1'b0, 31'd5);

    do_reset();
    regs[3] = 32'h0000_0015;
    regs[10] = 32'(10 * 16 + 5);
    fire(32'h0000_0073);
    run_dump(-1, 17, 1'b0, dc);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_abort_halted", 64'(halted), 64'd0);
    fire(32'h0000_0073);
    run_dump(-1, -1, 1'b0, dc);
    check_done(dc, 64, 1'b0, 31'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
